r_alu_arbiter: RTL and testbench
================================

# r_alu_arbiter

Sequencing and arbitration controller for the shared R-type ALU in the EX stage of the RV32I 5-stage pipeline. Two requesters (port 0: pipeline ID/EX issue; port 1: secondary issue source, e.g. debug/replay) present R-type operations with valid/ready handshakes. The block grants one request per cycle, registers the instruction word and operands that drive the ALU, and captures the combinational ALU result into a tagged response register. It also flags R-type encodings the ALU does not implement.

## Interface
Parameters:
- TAG_W, 4, width of the request/response tag

Ports:
- clk  in  1  core clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous kill of in-flight operation and pending response
- req_valid[1:0]  in  2  request valid per port
- req_ready[1:0]  out  2  request accepted this cycle (per port)
- req0_idata, req1_idata  in  32 each  instruction word
- req0_rv1, req0_rv2, req1_rv1, req1_rv2  in  32 each  rs1/rs2 values
- req0_tag, req1_tag  in  TAG_W each  requester tag
- alu_idata  out  32  registered instruction word to ALU
- alu_rv1, alu_rv2  out  32 each  registered operands to ALU
- alu_result  in  32  combinational ALU result for current alu_* outputs
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumer ready
- rsp_data  out  32  result (0 when rsp_err)
- rsp_tag  out  TAG_W  tag of the completed operation
- rsp_src  out  1  port that issued it
- rsp_err  out  1  illegal R-type encoding

## Operation
- States: IDLE (operand register empty), EXEC (operand register holds one operation).
- slot_free = (state==IDLE) or (state==EXEC and (!rsp_valid or rsp_ready)).
- Grant: at most one port. Round-robin, using a last-grant pointer. When both ports are valid, the port not granted last wins. The pointer updates only on an accepted request.
- req_ready[i] = grant[i] and slot_free and !flush. req_ready never depends on rsp_data/alu_result.
- Accept (req_valid[i] and req_ready[i]): alu_idata/alu_rv1/alu_rv2 load port i's values. Tag and source are stored. State becomes EXEC.
- EXEC with slot_free: at the edge, the response register loads alu_result, tag, src and err, and rsp_valid becomes 1. If a new request is accepted on the same edge, the block stays in EXEC. Otherwise it goes to IDLE.
- EXEC without slot_free (rsp_valid and !rsp_ready): operands are held, no request is accepted, and rsp_* is stable.
- Response handshake: rsp_valid and rsp_ready completes the response. If nothing new is loaded on that edge, rsp_valid drops to 0.
- Legality: bits {idata[31:25], idata[14:12]} of the operand register are checked.
  - funct7 = 0000000 is legal with any funct3.
  - funct7 = 0100000 is legal only with funct3 000 (SUB) or 101 (SRA).
  - Anything else gives rsp_err=1 and rsp_data=0.
- Opcode bits [6:0] are not checked; the decoder guarantees them.
- flush: at the edge, state becomes IDLE and rsp_valid becomes 0. Nothing is accepted in the flush cycle. The round-robin pointer is unchanged. Other rsp_* outputs keep their values, which are don't-care while rsp_valid=0.

## Timing
- Reset values: state IDLE, rsp_valid 0, rsp_data 0, rsp_tag 0, rsp_src 0, rsp_err 0, alu_idata/alu_rv1/alu_rv2 0. The pointer is set so that port 0 wins the first contention.
- Latency: a request accepted at edge T appears on rsp_* with rsp_valid=1 after edge T+1.
- Throughput: one operation per cycle while rsp_ready is held 1.
- Backpressure: when rsp_ready=0 with rsp_valid=1 and state EXEC, req_ready is 0 the next cycle. One operation is buffered in the operand register and one in the response register.
- Simultaneous response consume, new result and new accept on one edge: all three are legal and happen together.
- Reset asserted mid-operation: outputs return immediately (asynchronously) to reset values, and in-flight work is discarded.

## Configuration
- ALU_ARB_FIXED_PRIO_EN defined: port 0 always wins when both ports are valid, and the pointer logic is removed.
- ALU_ARB_FIXED_PRIO_EN not defined: round-robin as described in Operation.

## Test plan
- Single ADD on port 0 (rv1=5, rv2=7, tag=3), rsp_ready=1 -> rsp_valid one cycle after accept, rsp_data=12, rsp_tag=3, rsp_src=0, rsp_err=0; then IDLE.
- Both ports valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1. With ALU_ARB_FIXED_PRIO_EN: port 0 every cycle.
- Stream of SUB ops from port 1, rsp_ready low for 3 cycles mid-stream -> rsp_data held stable, req_ready=0 while stalled, no op lost or duplicated, order preserved.
- Illegal encoding funct7=0100000, funct3=111 -> rsp_err=1, rsp_data=0. SRA with rv1=0x80000000, rv2=4 -> rsp_data=0xF8000000, rsp_err=0.
- flush asserted while EXEC with rsp_valid=1, rsp_ready=0 -> next cycle rsp_valid=0, state IDLE, req_ready=0 during the flush cycle, pointer unchanged.
- rst_n pulled low mid-stream -> all outputs at reset values before the next clk edge. After release, the first contention grants port 0.

Source files
------------

// File: rtl/r_alu_arbiter.sv
// r_alu_arbiter: grants one of two R-type requesters per cycle, registers the
// instruction word and operands that drive the shared ALU, and captures the
// ALU result into a tagged response register.
// Optional feature macro: ALU_ARB_FIXED_PRIO_EN (port 0 always wins contention,
// no round-robin pointer). Undefined: round-robin on a last-grant pointer.
// Handshake (request and response sides): a transfer happens on a rising clk
// edge where valid and ready are both 1; a producer holds valid and payload
// until the transfer; ready may depend on valid but never on payload data.
module r_alu_arbiter #(
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [31:0]      req0_idata,
   input  logic [31:0]      req1_idata,
   input  logic [31:0]      req0_rv1,
   input  logic [31:0]      req0_rv2,
   input  logic [31:0]      req1_rv1,
   input  logic [31:0]      req1_rv2,
   input  logic [TAG_W-1:0] req0_tag,
   input  logic [TAG_W-1:0] req1_tag,
   output logic [31:0]      alu_idata,
   output logic [31:0]      alu_rv1,
   output logic [31:0]      alu_rv2,
   input  logic [31:0]      alu_result,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_data,
   output logic [TAG_W-1:0] rsp_tag,
   output logic             rsp_src,
   output logic             rsp_err,
   output logic             state_dbg
);

   typedef enum logic {IDLE, EXEC} state_t;

   state_t           state, state_nxt;
   logic [1:0]       grant;
   logic             slot_free;
   logic             accept;
   logic             acc_port;
   logic             legal;
   logic [6:0]       funct7;
   logic [2:0]       funct3;
   logic [TAG_W-1:0] op_tag;
   logic             op_src;

   // Operand register can take a new op when empty, or when its result can
   // move into a response register that is empty or draining this edge.
   assign slot_free = (state == IDLE) || (!rsp_valid || rsp_ready);
   assign req_ready = flush ? 2'b00 : (slot_free ? grant : 2'b00);
   assign accept    = |req_ready;
   assign acc_port  = req_ready[1];
   assign state_dbg = (state == EXEC);

   assign funct7 = alu_idata[31:25];
   assign funct3 = alu_idata[14:12];

   // Legality of the registered encoding; opcode is trusted from the decoder.
   always_comb begin
      legal = 1'b0;
      if (funct7 == 7'b0000000)
         legal = 1'b1;
      else if (funct7 == 7'b0100000)
         legal = (funct3 == 3'b000) || (funct3 == 3'b101);
   end

`ifdef ALU_ARB_FIXED_PRIO_EN
   // Fixed priority: port 0 wins whenever it is valid.
   always_comb begin
      grant = 2'b00;
      if (req_valid[0])
         grant = 2'b01;
      else if (req_valid[1])
         grant = 2'b10;
   end
`else
   logic last_grant;

   // Round-robin: on contention the port not granted last wins.
   always_comb begin
      grant = req_valid;
      if (req_valid == 2'b11)
         grant = last_grant ? 2'b01 : 2'b10;
   end

   // Pointer moves only on an accepted request; reset favours port 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         last_grant <= 1'b1;
      else if (accept)
         last_grant <= acc_port;
   end
`endif

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // FSM next state: flush empties, an accept fills, a drained EXEC empties.
   always_comb begin
      state_nxt = state;
      if (flush)
         state_nxt = IDLE;
      else if (accept)
         state_nxt = EXEC;
      else if ((state == EXEC) && slot_free)
         state_nxt = IDLE;
   end

   // Operand register: loads the granted port's op on accept.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_idata <= '0;
         alu_rv1   <= '0;
         alu_rv2   <= '0;
         op_tag    <= '0;
         op_src    <= 1'b0;
      end else if (accept) begin
         alu_idata <= acc_port ? req1_idata : req0_idata;
         alu_rv1   <= acc_port ? req1_rv1   : req0_rv1;
         alu_rv2   <= acc_port ? req1_rv2   : req0_rv2;
         op_tag    <= acc_port ? req1_tag   : req0_tag;
         op_src    <= acc_port;
      end
   end

   // Response register: captures the ALU result when the op moves out of EXEC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_tag   <= '0;
         rsp_src   <= 1'b0;
         rsp_err   <= 1'b0;
      end else if (flush) begin
         rsp_valid <= 1'b0;
      end else if ((state == EXEC) && slot_free) begin
         rsp_valid <= 1'b1;
         rsp_data  <= legal ? alu_result : 32'd0;
         rsp_tag   <= op_tag;
         rsp_src   <= op_src;
         rsp_err   <= !legal;
      end else if (rsp_valid && rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_r_alu_arbiter.sv
// tb_r_alu_arbiter: directed bench for r_alu_arbiter with a behavioural ALU
// on alu_result and a scoreboard of expected responses.
module tb_r_alu_arbiter;

   localparam int TAG_W = 4;
   localparam int W     = 34 + TAG_W;  // {err, src, tag, data}

   logic             clk;
   logic             rst_n;
   logic             flush;
   logic [1:0]       req_valid;
   logic [1:0]       req_ready;
   logic [31:0]      idata [2];
   logic [31:0]      rv1 [2];
   logic [31:0]      rv2 [2];
   logic [TAG_W-1:0] tag [2];
   logic [31:0]      alu_idata, alu_rv1, alu_rv2, alu_result;
   logic             rsp_valid, rsp_ready, rsp_src, rsp_err, state_dbg;
   logic [31:0]      rsp_data;
   logic [TAG_W-1:0] rsp_tag;

   logic [W-1:0]     exp_q [$];
   logic [1:0]       rdy_seen;
   logic [W-1:0]     got;
   logic [31:0]      held;
   logic [TAG_W-1:0] next_tag;
   int               total, bad;

   r_alu_arbiter #(.TAG_W(TAG_W)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .req_valid(req_valid), .req_ready(req_ready),
      .req0_idata(idata[0]), .req1_idata(idata[1]),
      .req0_rv1(rv1[0]), .req0_rv2(rv2[0]),
      .req1_rv1(rv1[1]), .req1_rv2(rv2[1]),
      .req0_tag(tag[0]), .req1_tag(tag[1]),
      .alu_idata(alu_idata), .alu_rv1(alu_rv1), .alu_rv2(alu_rv2),
      .alu_result(alu_result),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_tag(rsp_tag), .rsp_src(rsp_src), .rsp_err(rsp_err),
      .state_dbg(state_dbg)
   );

   // clock / watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // behavioural RV32I R-type ALU
   function automatic logic [31:0] alu_ref(input logic [31:0] id, input logic [31:0] a, input logic [31:0] b);
      logic [4:0] sh;
      sh = b[4:0];
      case (id[14:12])
         3'b000:  return id[30] ? a - b : a + b;
         3'b001:  return a << sh;
         3'b010:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3'b011:  return (a < b) ? 32'd1 : 32'd0;
         3'b100:  return a ^ b;
         3'b101:  return id[30] ? 32'($signed(a) >>> sh) : a >> sh;
         3'b110:  return a | b;
         default: return a & b;
      endcase
   endfunction

   function automatic logic legal_ref(input logic [31:0] id);
      case (id[31:25])
         7'h00:   return 1'b1;
         7'h20:   return (id[14:12] == 3'b000) || (id[14:12] == 3'b101);
         default: return 1'b0;
      endcase
   endfunction

   // ALU returns junk on unsupported encodings so a missing zeroing shows up.
   always_comb begin
      alu_result = 32'hDEADBEEF;
      if (legal_ref(alu_idata))
         alu_result = alu_ref(alu_idata, alu_rv1, alu_rv2);
   end

   function automatic logic [31:0] mk_r(input logic [6:0] f7, input logic [2:0] f3);
      return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
   endfunction

   function automatic logic [W-1:0] mk_exp(input int p);
      logic ok;
      ok = legal_ref(idata[p]);
      return {!ok, p[0], tag[p], ok ? alu_ref(idata[p], rv1[p], rv2[p]) : 32'd0};
   endfunction

   task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   // driver tasks
   task automatic set_op(input int p, input logic [31:0] id, input logic [31:0] a,
                         input logic [31:0] b, input logic [TAG_W-1:0] t);
      idata[p] = id;
      rv1[p]   = a;
      rv2[p]   = b;
      tag[p]   = t;
   endtask

   task automatic rand_op(input int p);
      logic [2:0] f3;
      logic [2:0] sel;
      logic [6:0] f7;
      f3  = 3'($urandom_range(0, 7));
      sel = 3'($urandom_range(0, 7));
      f7  = 7'h00;
      if (sel == 3'd0)
         f7 = 7'h01;
      else if (((f3 == 3'b000) || (f3 == 3'b101)) && sel[0])
         f7 = 7'h20;
      set_op(p, mk_r(f7, f3), $urandom, $urandom, next_tag);
      next_tag++;
   endtask

   // One clock: observe handshakes off-edge, feed scoreboard, advance.
   task automatic cycle();
      #1;
      rdy_seen = req_ready;
      if (rsp_valid && rsp_ready) begin
         check("rsp_expected", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0)
            check("rsp_payload", 64'({rsp_err, rsp_src, rsp_tag, rsp_data}), 64'(exp_q.pop_front()));
      end
      for (int p = 0; p < 2; p++)
         if (req_valid[p] && req_ready[p])
            exp_q.push_back(mk_exp(p));
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      req_valid = 2'b00;
      rsp_ready = 1'b1;
      repeat (3) cycle();
   endtask

   task automatic single_op(input int p, input logic [31:0] id, input logic [31:0] a,
                            input logic [31:0] b, input logic [TAG_W-1:0] t,
                            output logic [W-1:0] res);
      logic acc;
      logic seen;
      acc  = 1'b0;
      seen = 1'b0;
      set_op(p, id, a, b, t);
      req_valid = (p == 0) ? 2'b01 : 2'b10;
      rsp_ready = 1'b1;
      for (int i = 0; i < 10 && !acc; i++) begin
         cycle();
         acc = rdy_seen[p];
      end
      req_valid = 2'b00;
      check("accept_in_time", 64'(acc), 64'd1);
      for (int i = 0; i < 10 && !seen; i++) begin
         if (rsp_valid) seen = 1'b1;
         else cycle();
      end
      check("rsp_in_time", 64'(seen), 64'd1);
      res = {rsp_err, rsp_src, rsp_tag, rsp_data};
      cycle();
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      next_tag  = '0;
      rst_n     = 1'b0;
      flush     = 1'b0;
      req_valid = 2'b00;
      rsp_ready = 1'b0;
      for (int p = 0; p < 2; p++) set_op(p, 32'd0, 32'd0, 32'd0, '0);

      // reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_rsp_all", 64'({rsp_err, rsp_src, rsp_tag, rsp_data}), 64'd0);
      check("rst_alu", {alu_idata, alu_rv1 | alu_rv2}, 64'd0);
      check("rst_state", 64'(state_dbg), 64'd0);
      check("rst_req_ready", 64'(req_ready), 64'd0);
      rst_n = 1'b1;
      cycle();

      // single ADD on port 0: response one cycle after accept, then IDLE
      set_op(0, mk_r(7'h00, 3'b000), 32'd5, 32'd7, 4'd3);
      req_valid = 2'b01;
      rsp_ready = 1'b1;
      cycle();
      check("add_accept", 64'(rdy_seen), 64'd1);
      req_valid = 2'b00;
      check("add_exec", {63'd0, state_dbg}, 64'd1);
      check("add_not_yet", 64'(rsp_valid), 64'd0);
      cycle();
      check("add_rsp_valid", 64'(rsp_valid), 64'd1);
      check("add_rsp", 64'({rsp_err, rsp_src, rsp_tag, rsp_data}), {26'd0, 1'b0, 1'b0, 4'd3, 32'd12});
      check("add_idle", 64'(state_dbg), 64'd0);
      cycle();
      check("add_rsp_drop", 64'(rsp_valid), 64'd0);

      // both ports valid, rsp_ready high: one grant per cycle
      rand_op(0);
      rand_op(1);
      req_valid = 2'b11;
      rsp_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         cycle();
`ifdef ALU_ARB_FIXED_PRIO_EN
         check("fixed_grant", 64'(rdy_seen), 64'd1);
`else
         check("rr_grant", 64'(rdy_seen), (i % 2 == 0) ? 64'd2 : 64'd1);
`endif
         for (int p = 0; p < 2; p++)
            if (rdy_seen[p]) rand_op(p);
      end
      drain();

      // SUB stream on port 1 with a 3-cycle response stall
      set_op(1, mk_r(7'h20, 3'b000), $urandom, $urandom, next_tag);
      next_tag++;
      req_valid = 2'b10;
      held      = '0;
      for (int i = 0; i < 8; i++) begin
         rsp_ready = !(i >= 3 && i <= 5);
         if (i == 3) held = rsp_data;
         cycle();
         if (i >= 3 && i <= 5) begin
            check("stall_ready", 64'(rdy_seen), 64'd0);
            check("stall_data", 64'(rsp_data), 64'(held));
            check("stall_valid", 64'(rsp_valid), 64'd1);
         end
         if (rdy_seen[1]) begin
            set_op(1, mk_r(7'h20, 3'b000), $urandom, $urandom, next_tag);
            next_tag++;
         end
      end
      drain();
      check("stream_drained", 64'(exp_q.size()), 64'd0);

      // illegal encoding and SRA sign extension
      single_op(0, mk_r(7'h20, 3'b111), 32'h1234_5678, 32'h0F0F_0F0F, 4'd9, got);
      check("illegal_err", 64'(got[W-1]), 64'd1);
      check("illegal_data", 64'(got[31:0]), 64'd0);
      single_op(0, mk_r(7'h20, 3'b101), 32'h8000_0000, 32'd4, 4'd5, got);
      check("sra_rsp", 64'(got), {26'd0, 1'b0, 1'b0, 4'd5, 32'hF800_0000});

      // flush while EXEC with a stalled response
      drain();
      rsp_ready = 1'b0;
      rand_op(0);
      req_valid = 2'b01;
      cycle();
      rand_op(0);
      cycle();
      check("pre_flush_exec", 64'(state_dbg), 64'd1);
      check("pre_flush_valid", 64'(rsp_valid), 64'd1);
      rand_op(1);
      req_valid = 2'b11;
      flush     = 1'b1;
      cycle();
      check("flush_ready", 64'(rdy_seen), 64'd0);
      exp_q.delete();
      check("flush_rsp_valid", 64'(rsp_valid), 64'd0);
      check("flush_idle", 64'(state_dbg), 64'd0);
      rsp_ready = 1'b1;
      cycle();
      check("flush_idle_ready", 64'(rdy_seen), 64'd0);
      flush = 1'b0;
      cycle();
`ifdef ALU_ARB_FIXED_PRIO_EN
      check("post_flush_grant", 64'(rdy_seen), 64'd1);
`else
      check("post_flush_grant", 64'(rdy_seen), 64'd2);
`endif
      drain();

      // asynchronous reset in the middle of a stream
      rand_op(0);
      rand_op(1);
      req_valid = 2'b11;
      rsp_ready = 1'b1;
      repeat (3) begin
         cycle();
         for (int p = 0; p < 2; p++)
            if (rdy_seen[p]) rand_op(p);
      end
      #2;
      rst_n     = 1'b0;
      req_valid = 2'b00;
      #1;
      check("arst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("arst_rsp_all", 64'({rsp_err, rsp_src, rsp_tag, rsp_data}), 64'd0);
      check("arst_alu", {alu_idata, alu_rv1 | alu_rv2}, 64'd0);
      check("arst_state", 64'(state_dbg), 64'd0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      req_valid = 2'b11;
      cycle();
      check("post_rst_grant0", 64'(rdy_seen), 64'd1);
      for (int p = 0; p < 2; p++)
         if (rdy_seen[p]) rand_op(p);
      cycle();
`ifdef ALU_ARB_FIXED_PRIO_EN
      check("post_rst_grant1", 64'(rdy_seen), 64'd1);
`else
      check("post_rst_grant1", 64'(rdy_seen), 64'd2);
`endif
      drain();
      check("final_queue_empty", 64'(exp_q.size()), 64'd0);

      // final report
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
